// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller with 256-bit lines.
// One outstanding line transaction at a time; the CPU holds its request while stalled.
module dcache_controller #(
  parameter int unsigned INDEX_W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  input  logic         cpu_MemRead_i,
  input  logic         cpu_MemWrite_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  localparam int unsigned Lines = 1 << INDEX_W;
  localparam int unsigned TagW  = 27 - INDEX_W;

  typedef enum logic [2:0] {StIdle, StMiss, StWriteback, StAllocate, StRefill} state_e;

  state_e state_q, state_d;

  logic [Lines-1:0] valid_q, dirty_q;
  logic [TagW-1:0]  tag_q  [Lines];
  logic [255:0]     line_q [Lines];

  logic [INDEX_W-1:0] idx;
  logic [TagW-1:0]    req_tag;
  logic [2:0]         word;
  logic               req, hit, wr_hit, refill;
  logic               unused_addr;

  assign idx         = cpu_addr_i[5+INDEX_W-1:5];
  assign req_tag     = cpu_addr_i[31:5+INDEX_W];
  assign word        = cpu_addr_i[4:2];
  assign req         = cpu_MemRead_i | cpu_MemWrite_i;
  assign hit         = valid_q[idx] && (tag_q[idx] == req_tag);
  assign unused_addr = ^cpu_addr_i[1:0];

  always_comb begin
    state_d      = state_q;
    cpu_data_o   = '0;
    cpu_stall_o  = 1'b1;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    wr_hit       = 1'b0;
    refill       = 1'b0;
    unique case (state_q)
      StIdle: begin
        cpu_stall_o = req & ~hit;
        wr_hit      = cpu_MemWrite_i & hit;
        if (req && !hit) begin
          state_d = StMiss;
        end else if (cpu_MemRead_i && !cpu_MemWrite_i && hit) begin
          cpu_data_o = line_q[idx][{word, 5'b0} +: 32];
        end
      end
      StMiss: begin
        state_d = (valid_q[idx] && dirty_q[idx]) ? StWriteback : StAllocate;
      end
      StWriteback: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[idx], idx, 5'b0};
        mem_data_o   = line_q[idx];
        if (mem_ack_i) state_d = StAllocate;
      end
      StAllocate: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {req_tag, idx, 5'b0};
        if (mem_ack_i) state_d = StRefill;
      end
      StRefill: begin
        // Refill data arrives the cycle after the ack.
        refill  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (refill) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end else if (wr_hit) begin
        dirty_q[idx] <= 1'b1;
      end
    end
  end

  // Tags and data need no reset: they are qualified by valid.
  always_ff @(posedge clk_i) begin
    if (refill) begin
      tag_q[idx]  <= req_tag;
      line_q[idx] <= mem_data_i;
    end else if (wr_hit) begin
      line_q[idx][{word, 5'b0} +: 32] <= cpu_data_i;
    end
  end

endmodule
